// File: rtl/frame_unpack.sv
// Streaming decoder for 30-bit packed frames: recovers the 10 carried source
// bits, checks the fixed-pattern fields, and buffers results in a 2-entry FIFO.
module frame_unpack (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [29:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] out_data,
  output logic [14:0] out_mask,
  output logic        out_err,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count
);

  // Fixed-pattern bits of the frame: [26:23], [20:19], [15:14], [11:0].
  localparam logic [29:0] FIX_MASK = 30'h0798_CFFF;
  localparam logic [29:0] FIX_PAT  = 30'h0310_86E8;
  localparam logic [14:0] REC_MASK = 15'h7673;

  logic [14:0] dec_data;
  logic        dec_err;

  logic [15:0] mem_q [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [1:0]  wr_en;
  logic        push, pop;

  always_comb begin
    dec_data        = '0;
    dec_data[1:0]   = in_data[13:12];
    dec_data[6:4]   = in_data[18:16];
    dec_data[9]     = in_data[21];
    dec_data[10]    = ~in_data[22];
    dec_data[14:12] = in_data[29:27];
  end

  assign dec_err = (in_data & FIX_MASK) != FIX_PAT;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_q == 1'(gi));
    end
  endgenerate

  always_comb begin
    wr_ptr_d      = wr_ptr_q ^ push;
    rd_ptr_d      = rd_ptr_q ^ pop;
    count_d       = count_q + {1'b0, push} - {1'b0, pop};
    frame_count_d = frame_count_q;
    err_count_d   = err_count_q;
    if (push) begin
      frame_count_d = frame_count_q + 16'd1;
      if (dec_err && err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      frame_count_q <= '0;
      err_count_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
      for (int i = 0; i < 2; i++) begin
        if (wr_en[i]) begin
          mem_q[i] <= {dec_data, dec_err};
        end
      end
    end
  end

  assign out_data    = mem_q[rd_ptr_q][15:1];
  assign out_err     = mem_q[rd_ptr_q][0];
  assign out_mask    = REC_MASK;
  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_frame_unpack.sv
// Self-checking bench for frame_unpack: directed cases plus random traffic
// compared against a queue-based reference model.
module tb_frame_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_data;
  logic [14:0] out_mask;
  logic        out_err;
  logic [15:0] frame_count;
  logic [7:0]  err_count;

  frame_unpack dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mask(out_mask), .out_err(out_err),
    .frame_count(frame_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: queue of {data, err}, counters as plain ints.
  logic [15:0] mq [$];
  int          m_fc = 0;
  int          m_ec = 0;
  bit          model_ok = 0;
  bit          verbose = 1;

  localparam logic [29:0] GOOD_BASE = 30'h0310_86E8;
  localparam logic [29:0] FREE_BITS = 30'h3867_3000;
  int fixed_bits [20] = '{0,1,2,3,4,5,6,7,8,9,10,11,14,15,19,20,23,24,25,26};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_decode(input logic [29:0] f);
    logic [14:0] d;
    logic        e;
    d        = '0;
    d[1:0]   = f[13:12];
    d[6:4]   = f[18:16];
    d[9]     = f[21];
    d[10]    = !f[22];
    d[14:12] = f[29:27];
    e = ({f[26:23], f[20:19], f[15:14], f[11:0]} != 20'b0110_10_10_011011101000);
    return {d, e};
  endfunction

  function automatic logic [29:0] good_frame();
    return GOOD_BASE | (30'($urandom) & FREE_BITS);
  endfunction

  function automatic logic [29:0] bad_frame();
    logic [29:0] f;
    f = good_frame();
    f[fixed_bits[$urandom_range(0, 19)]] ^= 1'b1;
    return f;
  endfunction

  // One clock cycle: drive, compare against the model at negedge, advance the model.
  task automatic cycle(input bit v, input logic [29:0] d, input bit r, input bit rs);
    bit push, pop;
    logic [15:0] res;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    rst       = rs;
    @(negedge clk);
    if (model_ok) begin
      chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("out_data", 32'(out_data), 32'(mq[0][15:1]));
        chk("out_err", 32'(out_err), 32'(mq[0][0]));
      end
      chk("out_mask", 32'(out_mask), 32'h7673);
      chk("frame_count", 32'(frame_count), 32'(m_fc));
      chk("err_count", 32'(err_count), 32'(m_ec));
    end
    push = !rs && v && (mq.size() < 2);
    pop  = !rs && r && (mq.size() > 0);
    if (verbose && pop) $display("pop  data=%h err=%b", mq[0][15:1], mq[0][0]);
    if (verbose && push) $display("push frame=%h", d);
    @(posedge clk);
    #1;
    if (rs) begin
      mq.delete();
      m_fc = 0;
      m_ec = 0;
      model_ok = 1;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        res = ref_decode(d);
        mq.push_back(res);
        m_fc = (m_fc + 1) % 65536;
        if (res[0] && m_ec < 255) m_ec++;
      end
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, 30'h035086E8, 1'b0, 1'b1);
    cycle(1'b1, 30'h035086E8, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset with a frame being offered: nothing may be accepted.
    do_reset();
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);

    // Good, good, then bad frame with the consumer always ready.
    cycle(1'b1, 30'h3B37B6E8, 1'b1, 1'b0);
    chk("good1_data", 32'(out_data), 32'h7673);
    chk("good1_err", 32'(out_err), 32'd0);
    chk("good1_count", 32'(frame_count), 32'd1);
    cycle(1'b1, 30'h035086E8, 1'b1, 1'b0);
    chk("good2_data", 32'(out_data), 32'h0000);
    chk("good2_err", 32'(out_err), 32'd0);
    cycle(1'b1, 30'h035086E9, 1'b1, 1'b0);
    chk("bad_valid", 32'(out_valid), 32'd1);
    chk("bad_data", 32'(out_data), 32'h0000);
    chk("bad_err", 32'(out_err), 32'd1);
    chk("bad_err_count", 32'(err_count), 32'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Backpressure: three frames offered, only two fit.
    do_reset();
    cycle(1'b1, good_frame(), 1'b0, 1'b0);
    cycle(1'b1, good_frame(), 1'b0, 1'b0);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_count2", 32'(frame_count), 32'd2);
    in_data = good_frame();
    cycle(1'b1, in_data, 1'b0, 1'b0);
    chk("bp_still_full", 32'(frame_count), 32'd2);
    cycle(1'b1, in_data, 1'b1, 1'b0);
    chk("bp_after_pop", 32'(frame_count), 32'd2);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    cycle(1'b1, in_data, 1'b1, 1'b0);
    chk("bp_third_in", 32'(frame_count), 32'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Full-rate streaming.
    do_reset();
    for (int i = 0; i < 100; i++) cycle(1'b1, good_frame(), 1'b1, 1'b0);
    chk("stream_count", 32'(frame_count), 32'd100);

    // Error counter saturation.
    do_reset();
    verbose = 0;
    for (int i = 0; i < 300; i++) cycle(1'b1, bad_frame(), 1'b1, 1'b0);
    chk("err_sat", 32'(err_count), 32'd255);
    chk("err_sat_frames", 32'(frame_count), 32'd300);

    // Frame counter wrap.
    do_reset();
    for (int i = 0; i < 65536; i++) cycle(1'b1, good_frame(), 1'b1, 1'b0);
    chk("fc_wrap", 32'(frame_count), 32'd0);
    verbose = 1;

    // Random traffic with mixed frames, backpressure and one mid-stream reset.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [29:0] f;
      case ($urandom_range(0, 2))
        0: f = good_frame();
        1: f = bad_frame();
        default: f = 30'($urandom);
      endcase
      cycle(1'($urandom_range(0, 3) != 0), f, 1'($urandom_range(0, 2) != 0), i == 700);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_unpack.md
# frame_unpack

Streaming decoder for the 30-bit packed frame format that the packing stage produces from a 15-bit source word. Accepts frames over a valid/ready handshake and recovers the 10 source bits carried in the frame. Checks every fixed-pattern field and flags bad frames. Decoded words are buffered in a 2-entry output FIFO so that `in_ready` comes from a register, and the block keeps running frame and error counters for the bench and for status readout.

## Interface
- No parameters; all widths and field positions are fixed by the frame format.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `in_valid`  input  1  frame on `in_data` is valid.
- `in_ready`  output  1  block can accept a frame this cycle.
- `in_data`  input  30  packed frame.
- `out_valid`  output  1  decoded word available at FIFO head.
- `out_ready`  input  1  consumer accepts the head word this cycle.
- `out_data`  output  15  recovered source word; unrecoverable bits are 0.
- `out_mask`  output  15  constant 15'h7673; 1 marks a recovered bit position.
- `out_err`  output  1  head frame failed the fixed-field check.
- `frame_count`  output  16  frames accepted since reset; wraps.
- `err_count`  output  8  bad frames accepted since reset; saturates at 255.

## Operation
- Accept (push) when `in_valid && in_ready`. Pop when `out_valid && out_ready`.
- Field map for the decode, which is combinational on `in_data` before the FIFO write:
  - `in_data[13:12]` → `out_data[1:0]`
  - `in_data[18:16]` → `out_data[6:4]`
  - `in_data[21]` → `out_data[9]`
  - `~in_data[22]` → `out_data[10]`
  - `in_data[29:27]` → `out_data[14:12]`
  - `out_data[3:2]`, `[8:7]` and `[11]` are 0.
- Fixed-field check, where any mismatch sets `err` for that frame:
  - `[11:0]` must equal 12'b011011101000.
  - `[15:14]` must equal 2'b10.
  - `[20:19]` must equal 2'b10.
  - `[26:23]` must equal 4'b0110.
- A bad frame is still delivered, with the decoded data and `out_err`=1. The block never drops a frame.
- FIFO has 2 entries of {data[14:0], err} and a 2-bit occupancy count.
  - `in_ready` = (count != 2).
  - `out_valid` = (count != 0).
  - `out_data`/`out_err` are driven from the head entry.
- Counters update on push:
  - `frame_count` increments and wraps from 16'hFFFF to 0.
  - `err_count` increments on a bad frame and holds at 8'hFF once reached.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_data`=0, `out_err`=0.
  - `frame_count`=0, `err_count`=0.
  - FIFO empty, pointers 0.
- Latency: a frame pushed at edge N drives `out_valid`=1 with its data after edge N (visible in cycle N+1), provided the FIFO was empty.
- Push and pop in the same cycle:
  - count 1: count stays at 1, the head advances, and the new word becomes the head.
  - count 2: `in_ready`=0, so only the pop occurs and count becomes 1. `in_ready` rises in the next cycle; there is no combinational path from `out_ready` to `in_ready`.
- Full with no pop: `in_ready`=0. `in_data` is ignored, and the counters do not change.
- Empty with `out_ready`=1: no pop and no pointer movement.
- `out_data`/`out_err` hold stable while `out_valid && !out_ready`.
- Reset asserted mid-stream:
  - All FIFO contents are discarded, and both counters clear on the same edge.
  - A push in a cycle where `rst`=1 is ignored.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `in_valid`=1 and `in_data`=30'h035086E8 → `in_ready`=1, `out_valid`=0, `frame_count`=0, `err_count`=0 after release.
- **Good frames:** push 30'h3B37B6E8 with `out_ready`=1.
  - Next cycle: `out_data`=15'h7673, `out_err`=0, `frame_count`=1.
  - Then push 30'h035086E8 → `out_data`=15'h0000 (bit 10 inverted from frame bit 22=1), `out_err`=0.
- **Bad frame:** push 30'h035086E9 (bit 0 flipped) → `out_data`=15'h0000, `out_err`=1, `err_count`=1, frame still delivered.
- **Backpressure:** hold `out_ready`=0 and offer 3 frames back to back.
  - Only 2 are accepted; `in_ready`=0 after the second, and `frame_count`=2.
  - Raise `out_ready` → words emerge in order; the third frame is accepted one cycle after the first pop.
- **Full-rate streaming:** stream with `in_valid`=`out_ready`=1 for 100 cycles → 1 word per cycle, `in_ready` constantly 1, output order equals input order, `frame_count`=100.
- **Counter limits:**
  - Push 300 bad frames → `err_count` stops at 255.
  - Preload via 65 536 pushes → `frame_count` wraps to 0.
